regfile_serial_mp: RTL and testbench

Parametrised bit-serial register file with a self-timed serial pass controller. It serves two serial read operands per pass, with logical and arithmetic shift selection on operand 1. It captures a serial write-back stream into a destination register and also accepts parallel stores between passes. It sits between the instruction decoder/sequencer and the 1-bit ALU, replacing the fixed 8x8 serial register file.

---
 rtl/regfile_serial_pkg.sv | 20 ++
 rtl/regfile_bit_shifter.sv | 41 ++++
 rtl/regfile_serial_mp.sv | 138 +++++++++++++
 tb/tb_regfile_serial_mp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_serial_pkg.sv
// Shared types for the bit-serial register file: operand-1 shift modes and
// the serial pass controller states.
package regfile_serial_pkg;

    localparam int SHIFT_MODE_W = 2;

    typedef enum logic [SHIFT_MODE_W-1:0] {
        PASS = 2'b00,
        SLL  = 2'b01,
        SRL  = 2'b10,
        SRA  = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/regfile_bit_shifter.sv
// Combinational bit picker for serial operand 1: selects bit i of the word
// shifted by s under the requested mode. Index arithmetic is one bit wider
// than the bit index so i+s never wraps.
module regfile_bit_shifter
    import regfile_serial_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int IDX_W     = $clog2(REG_WIDTH)
) (
    input  logic [REG_WIDTH-1:0] word,
    input  logic [IDX_W-1:0]     idx,
    input  logic [IDX_W-1:0]     amt,
    input  shift_mode_e          mode,
    output logic                 bit_out
);

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(REG_WIDTH - 1);

    logic [IDX_W:0] i_ext;
    logic [IDX_W:0] s_ext;
    logic [IDX_W:0] sum;
    logic [IDX_W:0] diff;

    // Select the shifted bit; out-of-range positions fill with 0 or the sign bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        bit_out = 1'b0;
        i_ext   = {1'b0, idx};
        s_ext   = {1'b0, amt};
        sum     = i_ext + s_ext;
        diff    = i_ext - s_ext;
        case (mode)
            PASS: bit_out = word[idx];
            SLL:  if (i_ext >= s_ext) bit_out = word[diff[IDX_W-1:0]];
            SRL:  if (sum <= LAST)    bit_out = word[sum[IDX_W-1:0]];
            SRA:  bit_out = (sum <= LAST) ? word[sum[IDX_W-1:0]] : word[REG_WIDTH-1];
            default: bit_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_serial_mp.sv
// Parametrised bit-serial register file with a self-timed serial pass
// controller: two serial read operands (operand 1 shiftable), serial
// write-back committed at end of pass, parallel stores while idle.
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
module regfile_serial_mp
    import regfile_serial_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int REG_COUNT = 8,
    parameter int IDX_W     = $clog2(REG_WIDTH),
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       rs1_addr,
    input  logic [ADDR_W-1:0]       rs2_addr,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [SHIFT_MODE_W-1:0] shift_mode,
    input  logic [IDX_W-1:0]        shift_amt,
    input  logic                    wb_en,
    input  logic                    rd_bit,
    input  logic                    par_we,
    input  logic [ADDR_W-1:0]       par_addr,
    input  logic [REG_WIDTH-1:0]    par_data,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        bit_index,
    output logic                    rs1_bit,
    output logic                    rs2_bit,
    output logic [REG_WIDTH-1:0]    rs1_par
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_WIDTH - 1);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [REG_WIDTH-1:0]   regs [REG_COUNT];
    logic [REG_WIDTH-1:0]   wb_buf;
    logic [ADDR_W-1:0]      rs1_q, rs2_q, rd_q;
    shift_mode_e            mode_q;
    logic [IDX_W-1:0]       amt_q;
    logic                   wb_en_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [IDX_W-1:0]       amt_sat;
    logic                   accept;
    logic                   par_ok;
    logic                   commit_ok;
    logic                   sh_bit;

    // Shift distances beyond the register width saturate to the last bit.
    assign amt_sat   = ({1'b0, shift_amt} > {1'b0, LAST_IDX}) ? LAST_IDX : shift_amt;
    assign accept    = (state_q == IDLE) && start;
    assign par_ok    = (state_q == IDLE) && par_we && !(ZERO_REG && (par_addr == '0));
    assign commit_ok = (state_q == DONE) && wb_en_q && !(ZERO_REG && (rd_q == '0));

    // Controller state register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (bit_idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latches, bit counter, write-back capture and register array updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the register array is reset explicitly because an aborted pass must leave every register at zero.
            for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
            wb_buf    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            mode_q    <= PASS;
            amt_q     <= '0;
            wb_en_q   <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            if (accept) begin
                rs1_q   <= rs1_addr;
                rs2_q   <= rs2_addr;
                rd_q    <= rd_addr;
                mode_q  <= shift_mode_e'(shift_mode);
                amt_q   <= amt_sat;
                wb_en_q <= wb_en;
            end
            if (par_ok)    regs[par_addr] <= par_data;
            if (commit_ok) regs[rd_q]     <= wb_buf;
            if (state_q == SHIFT) begin
                wb_buf[bit_idx_q] <= rd_bit;
                bit_idx_q         <= (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
            end else begin
                bit_idx_q <= '0;
            end
        end
    end

    regfile_bit_shifter #(
        .REG_WIDTH (REG_WIDTH),
        .IDX_W     (IDX_W)
    ) u_shifter (
        .word    (regs[rs1_q]),
        .idx     (bit_idx_q),
        .amt     (amt_q),
        .mode    (mode_q),
        .bit_out (sh_bit)
    );

    assign bit_index = bit_idx_q;
    assign rs1_bit   = (state_q == SHIFT) && sh_bit;
    assign rs2_bit   = (state_q == SHIFT) && regs[rs2_q][bit_idx_q];
    assign rs1_par   = regs[rs1_addr];

endmodule

// File: tb/tb_regfile_serial_mp.sv
// Directed self-checking bench for regfile_serial_mp (8 x 8 configuration).
module tb_regfile_serial_mp;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int AW = 3;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [W-1:0] R0_EXP = 8'h00;
`else
    localparam logic [W-1:0] R0_EXP = 8'hFF;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          start = 1'b0;
    logic [AW-1:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic [1:0]    shift_mode = '0;
    logic [IW-1:0] shift_amt = '0;
    logic          wb_en = 1'b0;
    logic          rd_bit = 1'b0;
    logic          par_we = 1'b0;
    logic [AW-1:0] par_addr = '0;
    logic [W-1:0]  par_data = '0;
    logic          busy, done, rs1_bit, rs2_bit;
    logic [IW-1:0] bit_index;
    logic [W-1:0]  rs1_par;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_serial_mp #(.REG_WIDTH(W), .REG_COUNT(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .shift_mode (shift_mode),
        .shift_amt  (shift_amt),
        .wb_en      (wb_en),
        .rd_bit     (rd_bit),
        .par_we     (par_we),
        .par_addr   (par_addr),
        .par_data   (par_data),
        .busy       (busy),
        .done       (done),
        .bit_index  (bit_index),
        .rs1_bit    (rs1_bit),
        .rs2_bit    (rs2_bit),
        .rs1_par    (rs1_par)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic par_store(input logic [AW-1:0] a, input logic [W-1:0] d);
        par_addr = a;
        par_data = d;
        par_we   = 1'b1;
        tick();
        par_we   = 1'b0;
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [W-1:0] v);
        rs1_addr = a;
        #1;
        v = rs1_par;
    endtask

    // Runs one full pass from IDLE and returns to IDLE; reports the serial
    // streams, whether busy/bit_index tracked each bit, and the done cycle.
    task automatic do_pass(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [AW-1:0] ad, input logic [1:0] mode,
                           input logic [IW-1:0] amt, input logic wbe,
                           input logic [W-1:0] stream,
                           output logic [W-1:0] s1, output logic [W-1:0] s2,
                           output logic seq_ok, output int done_cyc);
        rs1_addr = a1; rs2_addr = a2; rd_addr = ad;
        shift_mode = mode; shift_amt = amt; wb_en = wbe;
        start = 1'b1;
        tick();
        start = 1'b0;
        seq_ok = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || bit_index !== IW'(k)) seq_ok = 1'b0;
            s1[k]  = rs1_bit;
            s2[k]  = rs2_bit;
            rd_bit = stream[k];
            tick();
        end
        rd_bit = 1'b0;
        done_cyc = -1;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = W + 1 + c;
            if (done_cyc < 0) tick();
        end
        tick();
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bit_index !== '0) begin errors++; $display("FAIL reset_bit_index: got %0d want 0", bit_index); end
        checks++; if ({rs1_bit, rs2_bit} !== 2'b00) begin errors++; $display("FAIL reset_operand_bits: got %b want 00", {rs1_bit, rs2_bit}); end
        tick();
        rstn = 1'b1;
        tick();
        peek(3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_r3: got %h want 00", v); end
    endtask

    task automatic test_pass_through();
        logic [W-1:0] v, s1, s2;
        logic ok;
        int dc;
        par_store(3, 8'hA5);
        peek(3, v);
        checks++; if (v !== 8'hA5) begin errors++; $display("FAIL par_store_r3: got %h want a5", v); end
        do_pass(3, 3, 0, 2'b00, 0, 1'b0, 8'h00, s1, s2, ok, dc);
        checks++; if (s1 !== 8'hA5) begin errors++; $display("FAIL pass_rs1_stream: got %h want a5", s1); end
        checks++; if (s2 !== 8'hA5) begin errors++; $display("FAIL pass_rs2_stream: got %h want a5", s2); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pass_bit_index_seq: got %b want 1", ok); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL pass_done_cycle: got %0d want 9", dc); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL pass_idle_after: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if ({rs1_bit, rs2_bit} !== 2'b00) begin errors++; $display("FAIL idle_operand_bits: got %b want 00", {rs1_bit, rs2_bit}); end
    endtask

    task automatic test_shift_modes();
        logic [AW-1:0] src [7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
        logic [1:0]    md  [7] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
        logic [IW-1:0] am  [7] = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd7, 3'd7, 3'd0};
        logic [W-1:0]  ex  [7] = '{8'hE5, 8'h25, 8'h58, 8'hFF, 8'h01, 8'h80, 8'h96};
        logic [W-1:0] s1, s2;
        logic ok;
        int dc;
        par_store(2, 8'h96);
        for (int t = 0; t < 7; t++) begin
            do_pass(src[t], 3, 0, md[t], am[t], 1'b0, 8'h00, s1, s2, ok, dc);
            checks++; if (s1 !== ex[t]) begin errors++; $display("FAIL shift_case%0d_rs1: got %h want %h", t, s1, ex[t]); end
            checks++; if (s2 !== 8'hA5) begin errors++; $display("FAIL shift_case%0d_rs2_unshifted: got %h want a5", t, s2); end
        end
    endtask

    task automatic test_writeback();
        logic [W-1:0] v, s1, s2;
        logic ok;
        int dc;
        par_store(4, 8'h0F);
        do_pass(4, 4, 4, 2'b00, 0, 1'b1, 8'h3C, s1, s2, ok, dc);
        checks++; if (s1 !== 8'h0F) begin errors++; $display("FAIL wb_rs1_old_value: got %h want 0f", s1); end
        checks++; if (s2 !== 8'h0F) begin errors++; $display("FAIL wb_rs2_old_value: got %h want 0f", s2); end
        peek(4, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL wb_commit_r4: got %h want 3c", v); end
        do_pass(4, 4, 4, 2'b00, 0, 1'b0, 8'hFF, s1, s2, ok, dc);
        peek(4, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL wb_disabled_r4: got %h want 3c", v); end
    endtask

    task automatic test_zero_reg();
        logic [W-1:0] v, s1, s2;
        logic ok;
        int dc;
        par_store(0, 8'hFF);
        peek(0, v);
        checks++; if (v !== R0_EXP) begin errors++; $display("FAIL r0_par_store: got %h want %h", v, R0_EXP); end
        do_pass(1, 0, 0, 2'b00, 0, 1'b1, 8'hFF, s1, s2, ok, dc);
        checks++; if (s2 !== R0_EXP) begin errors++; $display("FAIL r0_serial_read: got %h want %h", s2, R0_EXP); end
        peek(0, v);
        checks++; if (v !== R0_EXP) begin errors++; $display("FAIL r0_after_commit: got %h want %h", v, R0_EXP); end
    endtask

    task automatic test_ignore_mid_pass();
        logic [W-1:0] v;
        int busy_cnt = 0;
        par_store(5, 8'h11);
        rs1_addr = 5; rs2_addr = 5; rd_addr = 5; shift_mode = 2'b00; shift_amt = 0; wb_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin
            busy_cnt++;
            if (c == 3) begin
                start = 1'b1; par_we = 1'b1; par_addr = 5; par_data = 8'h77;
            end else if (c == 4) begin
                start = 1'b0; par_we = 1'b0;
            end
            tick();
        end
        checks++; if (busy_cnt !== W + 1) begin errors++; $display("FAIL busy_length: got %0d want %0d", busy_cnt, W + 1); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_not_queued: got busy=%b want 0", busy); end
        peek(5, v);
        checks++; if (v !== 8'h11) begin errors++; $display("FAIL par_we_dropped_r5: got %h want 11", v); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s1, s2;
        logic ok;
        int dc;
        do_pass(3, 2, 0, 2'b11, 1, 1'b0, 8'h00, s1, s2, ok, dc);
        checks++; if (s1 !== 8'hD2) begin errors++; $display("FAIL b2b_first_rs1: got %h want d2", s1); end
        do_pass(2, 3, 0, 2'b10, 1, 1'b0, 8'h00, s1, s2, ok, dc);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_accepted: got %b want 1", ok); end
        checks++; if (s1 !== 8'h4B) begin errors++; $display("FAIL b2b_second_rs1: got %h want 4b", s1); end
    endtask

    task automatic test_reset_midpass();
        logic [W-1:0] v, s1, s2;
        logic ok;
        int dc;
        rs1_addr = 3; rs2_addr = 3; rd_addr = 6; shift_mode = 2'b00; shift_amt = 0; wb_en = 1'b1;
        rd_bit = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++; if (bit_index !== 3'd4) begin errors++; $display("FAIL midpass_reach_bit4: got %0d want 4", bit_index); end
        rstn = 1'b0;
        #1;
        checks++; if ({busy, done, bit_index} !== 5'b0) begin errors++; $display("FAIL midpass_reset_outputs: got busy=%b done=%b idx=%0d want 0 0 0", busy, done, bit_index); end
        tick();
        rstn = 1'b1;
        rd_bit = 1'b0;
        tick();
        tick();
        peek(6, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL midpass_no_commit_r6: got %h want 00", v); end
        peek(3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL midpass_regs_cleared_r3: got %h want 00", v); end
        par_store(3, 8'h5A);
        do_pass(3, 3, 0, 2'b00, 0, 1'b0, 8'h00, s1, s2, ok, dc);
        checks++; if (ok !== 1'b1 || s1 !== 8'h5A) begin errors++; $display("FAIL midpass_restart: got ok=%b rs1=%h want 1 5a", ok, s1); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_shift_modes();
        test_writeback();
        test_zero_reg();
        test_ignore_mid_pass();
        test_back_to_back();
        test_reset_midpass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
